panel_serializer: RTL

PANEL_SERIALIZER -- requirements
Module: panel_serializer

---
 rtl/panel_serializer.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/panel_serializer.sv
// Dual-device 74HC595 chain driver: captures two words, shifts them out MSB
// first with a divided shift clock, latches them, then displays each one for a
// fixed dwell while alternating between the two devices.
module panel_serializer #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DIV   = 4,
    parameter int unsigned DWELL = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] rA,
    input  logic [WIDTH-1:0] rB,
    output logic             ser_out,
    output logic             shcp,
    output logic             stcp,
    output logic             oe_n,
    output logic [1:0]       dev_sel,
    output logic             busy,
    output logic             word_done
);
    localparam int unsigned   BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [7:0]    DIV_LAST = 8'(DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [15:0]   DW_LAST  = 16'(DWELL - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_LATCH, ST_DWELL} state_t;

    state_t           st, st_n;
    logic [7:0]       div_cnt, div_n;
    logic             ph, ph_n;           // 0: shcp low half, 1: shcp high half
    logic [BW-1:0]    bit_cnt, bit_n;
    logic [15:0]      dw_cnt, dw_n;
    logic             dev, dev_n;         // 0: device 1, 1: device 2
    logic [WIDTH-1:0] sh_a, sh_b, sa_n, sb_n;
    logic [WIDTH-1:0] pa, pb, pa_n, pb_n; // loads arriving mid-frame wait here
    logic             pend, pend_n;
    logic [WIDTH-1:0] word, word_n;       // MSB drives ser_out
    logic             dwell_end;
    logic             ser_d, shcp_d, stcp_d, oe_d, busy_d, done_d;
    logic [1:0]       sel_d;
    logic [1:0]       rst_sync;
    logic             rst_n_int;

    // Assert reset asynchronously, release it two clocks after rst rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n_int = rst_sync[1];

    // Next-state, counters, shadow update and next registered output values.
    always_comb begin
        st_n   = st;
        div_n  = div_cnt;
        ph_n   = ph;
        bit_n  = bit_cnt;
        dw_n   = dw_cnt;
        dev_n  = dev;
        sa_n   = sh_a;
        sb_n   = sh_b;
        pa_n   = pa;
        pb_n   = pb;
        pend_n = pend;
        word_n = word;
        dwell_end = (st == ST_DWELL) && (dw_cnt == DW_LAST);

        // A load mid-frame is parked until the next word boundary.
        if (load && (st != ST_IDLE) && !dwell_end) begin
            pa_n   = rA;
            pb_n   = rB;
            pend_n = 1'b1;
        end

        case (st)
            ST_IDLE: begin
                if (load) begin
                    st_n   = ST_SHIFT;
                    dev_n  = 1'b0;
                    sa_n   = rA;
                    sb_n   = rB;
                    word_n = rA;
                    div_n  = '0;
                    ph_n   = 1'b0;
                    bit_n  = '0;
                    pend_n = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    if (!ph) begin
                        ph_n = 1'b1;
                    end else begin
                        ph_n = 1'b0;
                        if (bit_cnt == BIT_LAST) begin
                            bit_n = '0;
                            st_n  = ST_LATCH;
                        end else begin
                            bit_n  = bit_cnt + BW'(1);
                            word_n = word << 1;
                        end
                    end
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end
            ST_LATCH: begin
                if (div_cnt == DIV_LAST) begin
                    div_n = '0;
                    dw_n  = '0;
                    st_n  = ST_DWELL;
                end else begin
                    div_n = div_cnt + 8'd1;
                end
            end
            default: begin
                if (dwell_end) begin
                    dw_n   = '0;
                    dev_n  = ~dev;
                    st_n   = ST_SHIFT;
                    div_n  = '0;
                    ph_n   = 1'b0;
                    bit_n  = '0;
                    pend_n = 1'b0;
                    // A load on this very cycle beats any parked one.
                    if (load) begin
                        sa_n = rA;
                        sb_n = rB;
                    end else if (pend) begin
                        sa_n = pa;
                        sb_n = pb;
                    end
                    word_n = dev_n ? sb_n : sa_n;
                end else begin
                    dw_n = dw_cnt + 16'd1;
                end
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        ser_d  = (st_n == ST_SHIFT) && word_n[WIDTH-1];
        shcp_d = (st_n == ST_SHIFT) && ph_n;
        stcp_d = (st_n == ST_LATCH);
        oe_d   = (st_n != ST_DWELL);
        sel_d  = (st_n == ST_DWELL) ? (dev_n ? 2'b10 : 2'b01) : 2'b00;
        busy_d = (st_n != ST_IDLE);
        done_d = (st_n == ST_DWELL) && (dw_n == DW_LAST);
    end

    // State, counters, shadows and output registers.
    always_ff @(posedge clk or negedge rst_n_int) begin
        if (!rst_n_int) begin
            st        <= ST_IDLE;
            div_cnt   <= '0;
            ph        <= 1'b0;
            bit_cnt   <= '0;
            dw_cnt    <= '0;
            dev       <= 1'b0;
            sh_a      <= '0;
            sh_b      <= '0;
            pa        <= '0;
            pb        <= '0;
            pend      <= 1'b0;
            word      <= '0;
            ser_out   <= 1'b0;
            shcp      <= 1'b0;
            stcp      <= 1'b0;
            oe_n      <= 1'b1;
            dev_sel   <= 2'b00;
            busy      <= 1'b0;
            word_done <= 1'b0;
        end else begin
            st        <= st_n;
            div_cnt   <= div_n;
            ph        <= ph_n;
            bit_cnt   <= bit_n;
            dw_cnt    <= dw_n;
            dev       <= dev_n;
            sh_a      <= sa_n;
            sh_b      <= sb_n;
            pa        <= pa_n;
            pb        <= pb_n;
            pend      <= pend_n;
            word      <= word_n;
            ser_out   <= ser_d;
            shcp      <= shcp_d;
            stcp      <= stcp_d;
            oe_n      <= oe_d;
            dev_sel   <= sel_d;
            busy      <= busy_d;
            word_done <= done_d;
        end
    end
endmodule
